// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared state type for the round-robin mux arbiter
package rr_mux_arbiter_pkg;
  typedef enum logic {IDLE, HOLD} state_e;
endpackage

// File: rtl/bN_mux_N_1.sv
// bN_mux_N_1: parameterised N:1 mux; d packed words in, sel index in, y selected word out
module bN_mux_N_1 #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2
) (
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] d,
  input  logic [ADDR_WIDTH-1:0]                    sel,
  output logic [DATA_WIDTH-1:0]                    y
);
  assign y = d[sel];
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational cyclic priority picker; req/ptr in, any (some request) and w (first request at or after ptr) out
module rr_pick #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic [2**ADDR_WIDTH-1:0] req,
  input  logic [ADDR_WIDTH-1:0]    ptr,
  output logic                     any,
  output logic [ADDR_WIDTH-1:0]    w
);
  localparam int N = 2**ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] idx;
  always_comb begin
    any = |req;
    w = '0;
    idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx = ptr + ADDR_WIDTH'(k);
      if (req[idx]) w = idx;
    end
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 capture arbiter; req/d in, one-hot gnt out, registered out_data/out_sel/out_valid with out_ready handshake
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [2**ADDR_WIDTH-1:0]                 req,
  input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] d,
  output logic [2**ADDR_WIDTH-1:0]                 gnt,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH-1:0]                    out_data,
  output logic [ADDR_WIDTH-1:0]                    out_sel
);
  localparam int N = 2**ADDR_WIDTH;
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, mux_y;
  logic [ADDR_WIDTH-1:0] sel_q, sel_d, ptr_q, ptr_d, w;
  logic any, grant;
  rr_pick #(.ADDR_WIDTH(ADDR_WIDTH)) u_pick (
    .req(req),
    .ptr(ptr_q),
    .any(any),
    .w(w)
  );
  bN_mux_N_1 #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux (
    .d(d),
    .sel(w),
    .y(mux_y)
  );
  always_comb begin
    grant = rst_n && (state_q == IDLE || out_ready) && any;
    gnt = grant ? N'(1) << w : '0;
    state_d = grant ? HOLD : (state_q == HOLD && out_ready) ? IDLE : state_q;
    data_d = grant ? mux_y : data_q;
    sel_d = grant ? w : sel_q;
    ptr_d = grant ? w + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      sel_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = state_q == HOLD;
  assign out_data = data_q;
  assign out_sel = sel_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;
  logic clk = 0;
  logic rst_n;
  logic [3:0] req;
  logic [3:0][1:0] d;
  logic [3:0] gnt;
  logic out_valid, out_ready;
  logic [1:0] out_data, out_sel;
  int errors = 0;
  int checks = 0;
  rr_mux_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .d(d),
    .gnt(gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sel(out_sel)
  );
  always #5 clk = ~clk;
  task tick;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    tick();
    rst_n = 0;
    req = 0;
    d = 0;
    out_ready = 0;
    #2;
    rst_n = 1;
  endtask
  task test_reset;
    rst_n = 0;
    req = 4'b1111;
    d = 8'hff;
    out_ready = 1;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++;
    if (out_data !== 2'd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", out_data); end
    checks++;
    if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", out_sel); end
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_clocked_valid got=%0b exp=0", out_valid); end
    do_reset();
  endtask
  task test_single_grant;
    do_reset();
    req = 4'b0100;
    d[2] = 2'b11;
    out_ready = 0;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL sg_gnt got=%b exp=0100", gnt); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 2'b11 || out_sel !== 2'd2) begin
      errors++; $display("FAIL sg_out got v=%0b data=%0d sel=%0d exp v=1 data=3 sel=2", out_valid, out_data, out_sel);
    end
    req = 4'b0000;
    d = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 2'b11 || out_sel !== 2'd2 || gnt !== 4'b0000) begin
        errors++; $display("FAIL sg_hold%0d got v=%0b data=%0d sel=%0d gnt=%b exp v=1 data=3 sel=2 gnt=0000", i, out_valid, out_data, out_sel, gnt);
      end
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sg_drain got=%0b exp=0", out_valid); end
  endtask
  task test_rotation;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 2'(i);
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (gnt !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rot_gnt%0d got=%b exp=%b", k, gnt, 4'(1 << (k % 4))); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 2'(k % 4)) begin
        errors++; $display("FAIL rot_out%0d got v=%0b sel=%0d data=%0d exp v=1 sel=%0d data=%0d", k, out_valid, out_sel, out_data, k % 4, k % 4);
      end
    end
  endtask
  task test_wrap;
    logic [1:0] exp_w [3];
    exp_w[0] = 0; exp_w[1] = 1; exp_w[2] = 0;
    do_reset();
    req = 4'b0100;
    out_ready = 1;
    tick();
    checks++;
    if (out_sel !== 2'd2) begin errors++; $display("FAIL wrap_pre got=%0d exp=2", out_sel); end
    req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (gnt !== 4'(1 << exp_w[k])) begin errors++; $display("FAIL wrap_gnt%0d got=%b exp=%b", k, gnt, 4'(1 << exp_w[k])); end
      tick();
      checks++;
      if (out_sel !== exp_w[k]) begin errors++; $display("FAIL wrap_sel%0d got=%0d exp=%0d", k, out_sel, exp_w[k]); end
    end
  endtask
  task test_hold_stable;
    do_reset();
    req = 4'b0001;
    d[0] = 2'd2;
    out_ready = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      req = 4'($urandom);
      d = 8'($urandom);
      #1;
      checks++;
      if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 2'd2) begin
        errors++; $display("FAIL hold%0d got gnt=%b v=%0b sel=%0d data=%0d exp gnt=0000 v=1 sel=0 data=2", k, gnt, out_valid, out_sel, out_data);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 2'd2) begin
      errors++; $display("FAIL hold_end got v=%0b sel=%0d data=%0d exp v=1 sel=0 data=2", out_valid, out_sel, out_data);
    end
  endtask
  task test_reset_mid_hold;
    do_reset();
    req = 4'b0100;
    d[2] = 2'd1;
    out_ready = 0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rmh_pre got=%0b exp=1", out_valid); end
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || gnt !== 4'b0000 || out_sel !== 2'd0) begin
      errors++; $display("FAIL rmh_async got v=%0b gnt=%b sel=%0d exp v=0 gnt=0000 sel=0", out_valid, gnt, out_sel);
    end
    #1;
    rst_n = 1;
    req = 4'b1000;
    out_ready = 1;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin errors++; $display("FAIL rmh_gnt3 got=%b exp=1000", gnt); end
    tick();
    checks++;
    if (out_sel !== 2'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL rmh_sel3 got v=%0b sel=%0d exp v=1 sel=3", out_valid, out_sel); end
    req = 4'b1001;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rmh_gnt0 got=%b exp=0001", gnt); end
    tick();
    checks++;
    if (out_sel !== 2'd0) begin errors++; $display("FAIL rmh_sel0 got=%0d exp=0", out_sel); end
  endtask
  task test_single_requester;
    do_reset();
    req = 4'b0010;
    d[1] = 2'd3;
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt%0d got=%b exp=0010", k, gnt); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 2'd3) begin
        errors++; $display("FAIL single_out%0d got v=%0b sel=%0d data=%0d exp v=1 sel=1 data=3", k, out_valid, out_sel, out_data);
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
  endtask
  initial begin
    test_reset();
    test_single_grant();
    test_rotation();
    test_wrap();
    test_hold_stable();
    test_reset_mid_hold();
    test_single_requester();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
